// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
// Holds the FSM state enum, port indices, abort read value and watchdog default.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_AUX = 1;

  localparam int TIMEOUT_DEF = 1024;

  // Wide enough for any supported data width; sliced to DW by users.
  localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin winner select, purely combinational.
// Ports: req[1:0] requests, last = index of previous owner, gnt one-hot winner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11) &&  last: gnt = 2'b01;
      (req == 2'b11) && !last: gnt = 2'b10;
      (req == 2'b01):          gnt = 2'b01;
      (req == 2'b10):          gnt = 2'b10;
      default:                 gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer between two strobe/ready masters and one slave.
// Ports: i_m0_*/i_m1_* master requests, o_m*_rdata/ready/err master replies,
//   o_mem_* slave strobe/command, i_mem_data/ready slave reply,
//   o_grant one-hot owner, o_timeouts saturating abort count.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  output logic [DW-1:0] o_m0_rdata,
  output logic          o_m0_ready,
  output logic          o_m0_err,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_m1_ready,
  output logic          o_m1_err,
  output logic          o_mem_clk,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  input  logic [DW-1:0] i_mem_data,
  input  logic          i_mem_ready,
  output logic [1:0]    o_grant,
  output logic [15:0]   o_timeouts
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_DW = ERR_RDATA[DW-1:0];

  arb_state_t state_q;
  arb_state_t state_d;

  logic           last_q;
  logic           owner_q;
  logic [WDW-1:0] wdog_q;
  logic [1:0]     req;
  logic [1:0]     win;
  logic           owner_req;
  logic           grant_en;
  logic           done_en;
  logic           abort_en;
  logic           exit_en;
  logic           wdog_inc;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;

  assign req = {i_m1_req, i_m0_req};

  rr_arb2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (win)
  );

  assign owner_req = (owner_q == 1'(PORT_AUX)) ? i_m1_req : i_m0_req;

  always_comb begin
    sel_we    = i_m0_we;
    sel_addr  = i_m0_addr;
    sel_wdata = i_m0_wdata;
    if (win[PORT_AUX]) begin
      sel_we    = i_m1_we;
      sel_addr  = i_m1_addr;
      sel_wdata = i_m1_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    done_en  = 1'b0;
    abort_en = 1'b0;
    exit_en  = 1'b0;
    wdog_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (i_mem_ready) begin
          done_en = 1'b1;
          state_d = DONE;
        end else if (wdog_q == WD_LAST) begin
          abort_en = 1'b1;
          state_d  = RECOVER;
        end else begin
          wdog_inc = 1'b1;
        end
      end
      DONE: begin
        // Four-phase: slave must also release ready before the bus is reused.
        if (!owner_req && !i_mem_ready) begin
          exit_en = 1'b1;
          state_d = IDLE;
        end
      end
      RECOVER: begin
        if (!owner_req) begin
          exit_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q     <= 1'(PORT_AUX);
      owner_q    <= 1'(PORT_CPU);
      wdog_q     <= '0;
      o_mem_clk  <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_grant    <= 2'b00;
      o_m0_rdata <= '0;
      o_m0_ready <= 1'b0;
      o_m0_err   <= 1'b0;
      o_m1_rdata <= '0;
      o_m1_ready <= 1'b0;
      o_m1_err   <= 1'b0;
      o_timeouts <= '0;
    end else begin
      if (grant_en) begin
        o_mem_clk  <= 1'b1;
        o_mem_we   <= sel_we;
        o_mem_addr <= sel_addr;
        o_mem_data <= sel_wdata;
        o_grant    <= win;
        owner_q    <= win[PORT_AUX];
        wdog_q     <= '0;
      end
      if (wdog_inc) wdog_q <= wdog_q + 1'b1;
      if (done_en || abort_en) o_mem_clk <= 1'b0;
      if (done_en) begin
        if (owner_q == 1'(PORT_AUX)) begin
          o_m1_rdata <= i_mem_data;
          o_m1_ready <= 1'b1;
          o_m1_err   <= 1'b0;
        end else begin
          o_m0_rdata <= i_mem_data;
          o_m0_ready <= 1'b1;
          o_m0_err   <= 1'b0;
        end
      end
      if (abort_en) begin
        if (owner_q == 1'(PORT_AUX)) begin
          o_m1_rdata <= ERR_DW;
          o_m1_ready <= 1'b1;
          o_m1_err   <= 1'b1;
        end else begin
          o_m0_rdata <= ERR_DW;
          o_m0_ready <= 1'b1;
          o_m0_err   <= 1'b1;
        end
        if (o_timeouts != 16'hFFFF) o_timeouts <= o_timeouts + 16'd1;
      end
      if (exit_en) begin
        o_m0_ready <= 1'b0;
        o_m0_err   <= 1'b0;
        o_m1_ready <= 1'b0;
        o_m1_err   <= 1'b0;
        o_grant    <= 2'b00;
        last_q     <= owner_q;
      end
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer for the shared 32-bit memory bus. It sits between the CPU bus master (port 0) and a secondary master such as DMA or video fetch (port 1) on one side, and the memory/IO slave on the other. Each side uses the same strobe/ready four-phase handshake the CPU already drives. The block adds round-robin fairness, transaction latching and a bus watchdog timeout.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 1024, maximum cycles a slave may take to raise ready before abort (must be ≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_m0_req / i_m1_req  in  1  master strobe (bus_clk equivalent), held until ready seen
- i_m0_we / i_m1_we  in  1  write enable, valid while req high
- i_m0_addr / i_m1_addr  in  AW  address
- i_m0_wdata / i_m1_wdata  in  DW  write data
- o_m0_rdata / o_m1_rdata  out  DW  read data, valid while matching ready high
- o_m0_ready / o_m1_ready  out  1  transfer complete, held until that master drops req
- o_m0_err / o_m1_err  out  1  transfer aborted by timeout, qualifies ready
- o_mem_clk  out  1  slave strobe
- o_mem_we  out  1  slave write enable
- o_mem_addr  out  AW  slave address
- o_mem_data  out  DW  slave write data
- i_mem_data  in  DW  slave read data
- i_mem_ready  in  1  slave completion
- o_grant  out  2  one-hot owner; 00 when idle
- o_timeouts  out  16  saturating count of aborted transfers

## Operation
- FSM states: IDLE, BUSY, DONE, RECOVER.
- IDLE: if any req is high, select the winner, latch its we/addr/wdata into o_mem_*, set o_mem_clk=1 and o_grant, clear the watchdog, go to BUSY.
- Arbitration is round-robin. If both masters request, the port not granted last wins. The last-grant register resets to port 1, so port 0 wins the first contention. A single requester always wins.
- BUSY:
  - If i_mem_ready=1: drop o_mem_clk, capture i_mem_data into the winner's rdata (also on writes), set winner ready=1 and err=0, go to DONE.
  - Else if watchdog=TIMEOUT-1: drop o_mem_clk, set rdata=all ones, ready=1, err=1, increment o_timeouts (saturate at FFFF), go to RECOVER.
  - Otherwise increment the watchdog.
- DONE: hold ready, rdata and err until the winner's req=0 AND i_mem_ready=0. Then clear ready/err and o_grant, update last-grant, go to IDLE.
- RECOVER: same exit rule as DONE, but the exit does not require i_mem_ready=0.
- A req dropped during BUSY does not abort. The transfer completes, ready is shown for at least one cycle, then the FSM exits.
- The loser's req is ignored, and its ready stays 0, until the FSM returns to IDLE.
- o_mem_addr, o_mem_we and o_mem_data stay stable from the grant edge through completion.

## Timing
- Reset (async) sets: FSM=IDLE, all ready/err/o_mem_clk/o_mem_we=0, all addr/data/rdata=0, o_grant=00, o_timeouts=0, last-grant=port 1.
- Reset asserted mid-transfer aborts immediately. No completion or err is reported.
- Grant latency: req sampled high at edge k in IDLE → o_mem_clk=1 after edge k.
- Completion latency: i_mem_ready sampled high at edge j → master ready=1 and o_mem_clk=0 after edge j.
- Minimum transaction, req high to ready high: 2 edges when the slave answers combinationally on the strobe.
- Turnaround: req low sampled at edge m in DONE → IDLE after m. The next grant can occur at edge m+1, giving one idle cycle between transfers.
- Timeout fires on the TIMEOUT-th BUSY edge without ready.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, DONE, RECOVER)
  - port index constants PORT_CPU=0, PORT_AUX=1
  - ERR_RDATA (all ones)
  - the TIMEOUT default
- Sub-module rr_arb2 (combinational winner select from req[1:0] and last-grant) is natural and is tested standalone.
- The top level holds the FSM, latches, watchdog and counter.

## Test plan
- Port 0 read of addr 0x1234, slave returns 0xA5 three cycles after strobe → o_mem_addr=0x1234, we=0, m0_rdata=0xA5, m0_ready=1, err=0, o_grant=01 throughout.
- Both req same edge from reset, then both re-request → port 0 served first, port 1 second, port 0 third (strict alternation). Idle gap of exactly one cycle between strobes.
- Port 1 write 0xDEADBEEF to 0x8000 while port 0 requests mid-transfer → o_mem_data stable at 0xDEADBEEF, port 0 is granted only after m1 req drops.
- Slave never asserts ready, TIMEOUT=8 → strobe drops after 8 BUSY edges, rdata=0xFFFFFFFF, ready=1, err=1, o_timeouts=1. The next request proceeds normally.
- i_rst asserted during BUSY → all outputs are zero asynchronously. After release, a fresh port 0 request completes correctly.
- Port 0 drops req one cycle after grant, slave ready at cycle 4 → ready pulses at least one cycle, then the FSM returns to IDLE without a hang.
